// File: rtl/cv32e40p_fpu_arbiter.sv
// cv32e40p_fpu_arbiter
// Shares one FPU instance between NUM_REQ requesters. A round-robin arbiter fills a single
// registered issue slot toward the FPU. The requester index travels with the operation as the FPU
// tag, and each result is steered back to its owner by that tag. The number of operations in
// flight (granted but not yet responded, including the one in the issue slot) is capped at
// MAX_OUTSTANDING, so the FPU pipe registers never overflow.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i/o      per-requester request valid / grant (req_ready_o is one-hot or zero)
//   req_data_i         request payloads, requester i at [i*REQ_W +: REQ_W]
//   fpu_valid_o/...    issue slot toward the FPU (valid, ready, payload, requester tag)
//   fpu_rvalid_i/...   result from the FPU (valid, ready, payload, tag)
//   rsp_valid_o/...    per-requester response valid/ready; rsp_data_o is broadcast
//   busy_o             at least one operation outstanding
//   grant_cnt_o        per-requester saturating grant counters (only when the macro
//                      CV32E40P_FPU_ARB_PERF_EN is defined)
module cv32e40p_fpu_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned REQ_W           = 110,
  parameter int unsigned RSP_W           = 37,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IDX_W           = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*REQ_W-1:0] req_data_i,
  output logic                     fpu_valid_o,
  input  logic                     fpu_ready_i,
  output logic [REQ_W-1:0]         fpu_data_o,
  output logic [IDX_W-1:0]         fpu_tag_o,
  input  logic                     fpu_rvalid_i,
  output logic                     fpu_rready_o,
  input  logic [RSP_W-1:0]         fpu_rdata_i,
  input  logic [IDX_W-1:0]         fpu_rtag_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [RSP_W-1:0]         rsp_data_o,
  output logic                     busy_o
`ifdef CV32E40P_FPU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]    grant_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             valid_q, valid_d;
  logic [REQ_W-1:0] data_q, data_d;
  logic [IDX_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             can_grant;
  logic             found_hi, found_any;
  logic [IDX_W-1:0] idx_hi, idx_any, gnt_idx;
  logic [REQ_W-1:0] gnt_data;
  logic             gnt_hs, rsp_hs;

  assign can_grant = (!valid_q || fpu_ready_i) && (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

  // Round-robin: the lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest
  // valid index overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        found_any = 1'b1;
        idx_any   = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_any;
  end

  assign gnt_hs = can_grant && found_any;

  always_comb begin
    req_ready_o = '0;
    gnt_data    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        req_ready_o[i] = gnt_hs;
        gnt_data       = req_data_i[i*REQ_W +: REQ_W];
      end
    end
  end

  // Issue slot: load on grant, clear on accept, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_hs) begin
      valid_d  = 1'b1;
      data_d   = gnt_data;
      tag_d    = gnt_idx;
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (valid_q && fpu_ready_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      tag_d   = '0;
    end
  end

  // Response demux; tags outside the requester range select nobody.
  always_comb begin
    rsp_valid_o  = '0;
    fpu_rready_o = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (fpu_rtag_i == IDX_W'(i)) begin
        rsp_valid_o[i] = fpu_rvalid_i;
        fpu_rready_o   = rsp_ready_i[i];
      end
    end
  end

  assign rsp_data_o = fpu_rdata_i;
  assign rsp_hs     = fpu_rvalid_i && fpu_rready_o;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (gnt_hs && !rsp_hs) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!gnt_hs && rsp_hs) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      rr_ptr_q  <= rr_ptr_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign fpu_valid_o = valid_q;
  assign fpu_data_o  = data_q;
  assign fpu_tag_o   = tag_q;
  assign busy_o      = (out_cnt_q != '0);

`ifdef CV32E40P_FPU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready_o[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

  // A result can only belong to an operation that is already in flight.
  a_rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    fpu_rvalid_i |-> (out_cnt_q != '0));
  a_rtag_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    fpu_rvalid_i |-> (32'(fpu_rtag_i) < NUM_REQ));
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(out_cnt_q) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_cv32e40p_fpu_arbiter.sv
module tb_cv32e40p_fpu_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int unsigned ReqW   = 110;
  localparam int unsigned RspW   = 37;
  localparam int unsigned IdxW   = 1;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq-1:0]      req_ready_o;
  logic [NumReq*ReqW-1:0] req_data_i;
  logic                   fpu_valid_o;
  logic                   fpu_ready_i;
  logic [ReqW-1:0]        fpu_data_o;
  logic [IdxW-1:0]        fpu_tag_o;
  logic                   fpu_rvalid_i;
  logic                   fpu_rready_o;
  logic [RspW-1:0]        fpu_rdata_i;
  logic [IdxW-1:0]        fpu_rtag_i;
  logic [NumReq-1:0]      rsp_valid_o;
  logic [NumReq-1:0]      rsp_ready_i;
  logic [RspW-1:0]        rsp_data_o;
  logic                   busy_o;

  logic [ReqW-1:0] d0, d1;
  int n_assert = 0;
  int n_fail   = 0;

  assign req_data_i = {d1, d0};

  always #5 clk_i = ~clk_i;

  cv32e40p_fpu_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .fpu_valid_o  (fpu_valid_o),
    .fpu_ready_i  (fpu_ready_i),
    .fpu_data_o   (fpu_data_o),
    .fpu_tag_o    (fpu_tag_o),
    .fpu_rvalid_i (fpu_rvalid_i),
    .fpu_rready_o (fpu_rready_o),
    .fpu_rdata_i  (fpu_rdata_i),
    .fpu_rtag_i   (fpu_rtag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the coming cycle, then let combinational outputs settle.
  task automatic drive(input logic [1:0] v, input logic fr, input logic rv, input logic rt,
                       input logic [1:0] rr);
    req_valid_i  = v;
    fpu_ready_i  = fr;
    fpu_rvalid_i = rv;
    fpu_rtag_i   = rt;
    rsp_ready_i  = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic t,
                          input logic [ReqW-1:0] d);
    chk({tag, ".fpu_valid"}, 128'(fpu_valid_o), 128'(v));
    chk({tag, ".fpu_tag"},   128'(fpu_tag_o),   128'(t));
    chk({tag, ".fpu_data"},  128'(fpu_data_o),  128'(d));
  endtask

  initial begin
    d0          = 110'h0A5A_1234_5678_9ABC_DEF0_0001;
    d1          = 110'h1C3C_8765_4321_0FED_CBA9_0002;
    fpu_rdata_i = 37'h1F_1234_ABCD;
    rst_i       = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();

    // Reset state
    chk_slot("reset", 1'b0, 1'b0, '0);
    chk("reset.busy",  128'(busy_o), 128'(0));
    rst_i = 1'b0;

    // Single request from requester 0
    drive(2'b01, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("single.ready", 128'(req_ready_o), 128'(2'b01));
    tick();
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    chk_slot("single.issue", 1'b1, 1'b0, d0);
    chk("single.busy", 128'(busy_o), 128'(1));
    tick();
    drive(2'b00, 1'b1, 1'b1, 1'b0, 2'b01);
    chk_slot("single.accepted", 1'b0, 1'b0, '0);
    chk("single.rsp_valid", 128'(rsp_valid_o), 128'(2'b01));
    chk("single.rready",    128'(fpu_rready_o), 128'(1));
    chk("single.rsp_data",  128'(rsp_data_o), 128'(37'h1F_1234_ABCD));
    tick();
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("single.idle_busy", 128'(busy_o), 128'(0));

    // Both requesting; rr_ptr is 1 after the single grant to 0
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
    chk("rr.c1_ready", 128'(req_ready_o), 128'(2'b10));
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
    chk_slot("rr.c2", 1'b1, 1'b1, d1);
    chk("rr.c2_ready", 128'(req_ready_o), 128'(2'b01));
    tick();
    // Count is 2: response this cycle must not enable a grant
    drive(2'b11, 1'b1, 1'b1, 1'b1, 2'b11);
    chk_slot("rr.c3", 1'b1, 1'b0, d0);
    chk("rr.c3_ready_full", 128'(req_ready_o), 128'(2'b00));
    chk("rr.c3_rsp_valid",  128'(rsp_valid_o), 128'(2'b10));
    chk("rr.c3_rready",     128'(fpu_rready_o), 128'(1));
    tick();
    // Count is 1: grant and response together keep it at 1
    drive(2'b11, 1'b1, 1'b1, 1'b0, 2'b11);
    chk_slot("rr.c4", 1'b0, 1'b0, '0);
    chk("rr.c4_ready", 128'(req_ready_o), 128'(2'b10));
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
    chk_slot("rr.c5", 1'b1, 1'b1, d1);
    chk("rr.c5_ready_cnt1", 128'(req_ready_o), 128'(2'b01));
    tick();

    // FPU stalls 5 cycles; response to tag 1 refused by its owner
    drive(2'b11, 1'b0, 1'b1, 1'b1, 2'b01);
    chk("stall.rsp_valid", 128'(rsp_valid_o), 128'(2'b10));
    chk("stall.rready",    128'(fpu_rready_o), 128'(0));
    chk("stall.ready",     128'(req_ready_o), 128'(2'b00));
    tick();
    d0 = 110'h2222_3333_4444_5555_6666_7777;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b00);
      chk_slot("stall.hold", 1'b1, 1'b0, 110'h0A5A_1234_5678_9ABC_DEF0_0001);
      chk("stall.hold_ready", 128'(req_ready_o), 128'(2'b00));
      tick();
    end
    // Slot drains; count must still be 2 because the refused response was not consumed
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
    chk_slot("held.slot_empty", 1'b0, 1'b0, '0);
    chk("held.ready_blocked", 128'(req_ready_o), 128'(2'b00));
    tick();
    drive(2'b00, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    // Count 1, slot empty: refill slot with requester 0 while FPU stalls
    drive(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("refill.ready", 128'(req_ready_o), 128'(2'b01));
    tick();

    // Reset with slot full and count 2
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    chk_slot("prerst", 1'b1, 1'b0, d0);
    chk("prerst.busy", 128'(busy_o), 128'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b00);
    chk_slot("postrst", 1'b0, 1'b0, '0);
    chk("postrst.busy",   128'(busy_o), 128'(0));
    chk("postrst.rr_ptr", 128'(req_ready_o), 128'(2'b01));
    tick();
    chk_slot("postrst.issue", 1'b1, 1'b0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
